if_fetch_queue: RTL

Parametrised successor to the single-register fetch stage. It owns the word-addressed PC, drives the instruction-memory read address, and buffers fetched {PC+1, instr} pairs in a DEPTH-entry FIFO. The FIFO feeds ID through a valid/ready handshake, so a stalled ID no longer stops fetch until the queue is full. Redirects from branch/jump resolution flush the queue and reload the PC in one cycle.

---
 rtl/if_fetch_queue.sv | 97 +++++++++
 1 files changed

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage with a DEPTH-entry queue of {PC+1, instr} pairs.
// It owns the word-addressed PC, feeds ID through valid/ready, and flushes on redirect.
module if_fetch_queue #(
  parameter int unsigned     PC_W     = 30,
  parameter int unsigned     IM_AW    = 10,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_en,
  input  logic                     redirect,
  input  logic [PC_W-1:0]          redirect_pc,
  output logic [IM_AW-1:0]         imem_addr,
  input  logic [31:0]              imem_rdata,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [PC_W-1:0]          id_pcp1,
  output logic [31:0]              id_instr,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic [PC_W-1:0]          fetch_pc
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [PC_W-1:0] pcp1;
    logic [31:0]     instr;
  } entry_t;

  entry_t            mem_q [DEPTH];
  entry_t            head_entry;
  logic [PC_W-1:0]   pc_q, pc_d, pc_inc;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              deq, enq;

  assign pc_inc = pc_q + PC_W'(1);
  assign deq    = id_valid & id_ready;
  // When full, a simultaneous dequeue frees the slot the enqueue writes.
  assign enq    = fetch_en & ~redirect & ((count_q < CNT_W'(DEPTH)) | deq);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (redirect) begin
      pc_d    = redirect_pc;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) begin
        pc_d   = pc_inc;
        tail_d = tail_q + PTR_W'(1);
      end
      if (deq) begin
        head_d = head_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: queue storage is deliberately not reset; count gates every read to the outputs.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_q[tail_q] <= '{pcp1: pc_inc, instr: imem_rdata};
    end
  end

  assign head_entry = mem_q[head_q];
  assign id_valid   = (count_q != '0);
  assign id_pcp1    = id_valid ? head_entry.pcp1  : '0;
  assign id_instr   = id_valid ? head_entry.instr : '0;
  assign q_count    = count_q;
  assign fetch_pc   = pc_q;
  assign imem_addr  = pc_q[IM_AW-1:0];

endmodule
